sr_latch_bank: RTL and testbench

- Parametrised, clocked bank of SR latches for the magnetron control path.
- Successor to the single asynchronous SR latch.
- Each channel is a synchronous SR flip-flop with a configurable response to simultaneous S/R and a post-reset lockout window that blocks re-arming, protecting the magnetron against rapid on/off cycling.
- Sits between the start/stop/door decode logic and the magnetron drive enables.

---
 rtl/sr_latch_pkg.sv | 51 +++++
 rtl/sr_latch_chan.sv | 107 ++++++++++
 rtl/sr_latch_bank.sv | 52 +++++
 tb/tb_sr_latch_bank.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// ---------------------------------------------------------------------------
// sr_latch_pkg
// Shared definitions for the clocked SR latch bank on the magnetron control
// path: simultaneous-S/R response modes, per-channel state encoding, the
// decoded command set and the helper that turns raw s/r into a command.
// No ports (package).
// ---------------------------------------------------------------------------
package sr_latch_pkg;

  // Response when s and r are both high
  localparam logic [1:0] MODE_RST_DOM = 2'd0;
  localparam logic [1:0] MODE_SET_DOM = 2'd1;
  localparam logic [1:0] MODE_HOLD    = 2'd2;
  localparam logic [1:0] MODE_TOGGLE  = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_LOCK = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_SET  = 2'd1,
    CMD_RST  = 2'd2,
    CMD_TOG  = 2'd3
  } cmd_e;

  // Collapse one channel's s/r pair into the effective command; the
  // simultaneous case is resolved by the configured mode.
  function automatic cmd_e decode_cmd(input logic s, input logic r,
                                      input logic [1:0] mode);
    cmd_e cmd;
    cmd = CMD_NONE;
    case ({s, r})
      2'b10: cmd = CMD_SET;
      2'b01: cmd = CMD_RST;
      2'b11: begin
        case (mode)
          MODE_RST_DOM: cmd = CMD_RST;
          MODE_SET_DOM: cmd = CMD_SET;
          MODE_HOLD:    cmd = CMD_NONE;
          default:      cmd = CMD_TOG;
        endcase
      end
      default: cmd = CMD_NONE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sr_latch_chan.sv
// ---------------------------------------------------------------------------
// sr_latch_chan
// One channel of the SR latch bank: command decode, OFF/ON/LOCK state
// machine, lockout counter and conflict flag.
//
// Configuration macro: SR_LATCH_BANK_STICKY_CONFLICT_EN
//   defined   -> conflict is sticky until rst
//   undefined -> conflict is the one-cycle registered s&r
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset
//   s        in  set request
//   r        in  reset request
//   q        out latch state (1 = magnetron enable)
//   lockout  out high while the channel is in its post-reset lockout
//   conflict out s and r were both high (see macro above)
// ---------------------------------------------------------------------------
module sr_latch_chan
  import sr_latch_pkg::*;
#(
  parameter int BOTH_MODE      = 0,
  parameter int LOCKOUT_CYCLES = 8,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic lockout,
  output logic conflict
);

  // A zero-cycle lockout would give a zero-width counter; keep at least 1 bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam bit HAS_LOCK = (LOCKOUT_CYCLES > 0);
  localparam logic [1:0] MODE = 2'(BOTH_MODE);
  localparam logic [CW-1:0] LOAD =
      HAS_LOCK ? CW'(LOCKOUT_CYCLES - 1) : '0;

  state_e        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          conflict_q;
  cmd_e          cmd;

  assign cmd = decode_cmd(s, r, MODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OFF;
      cnt        <= '0;
      conflict_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef SR_LATCH_BANK_STICKY_CONFLICT_EN
      conflict_q <= conflict_q | (s & r);
`else
      conflict_q <= s & r;
`endif
    end
  end

  // Loading LOAD (= LOCKOUT_CYCLES-1) and leaving LOCK only once the counter
  // has reached zero gives exactly LOCKOUT_CYCLES cycles of lockout. SET/TOG
  // arriving during LOCK are dropped; RST restarts the window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_OFF: begin
        if (cmd == CMD_SET || cmd == CMD_TOG) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (cmd == CMD_RST || cmd == CMD_TOG) begin
          if (HAS_LOCK) begin
            state_nxt = ST_LOCK;
            cnt_nxt   = LOAD;
          end else begin
            state_nxt = ST_OFF;
          end
        end
      end
      ST_LOCK: begin
        if (cmd == CMD_RST) begin
          cnt_nxt = LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_OFF;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign q        = (state == ST_ON);
  assign lockout  = (state == ST_LOCK);
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// ---------------------------------------------------------------------------
// sr_latch_bank
// Parametrised bank of clocked SR latches driving the magnetron enables.
// Each channel is an independent sr_latch_chan; this level only slices the
// buses.
//
// Configuration macro: SR_LATCH_BANK_STICKY_CONFLICT_EN (see sr_latch_chan)
//
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-high reset
//   s        in  [CHANNELS] per-channel set request
//   r        in  [CHANNELS] per-channel reset request
//   q        out [CHANNELS] per-channel latch state
//   lockout  out [CHANNELS] channel is in post-reset lockout
//   conflict out [CHANNELS] s and r were both high
// ---------------------------------------------------------------------------
module sr_latch_bank
  import sr_latch_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int BOTH_MODE      = 0,
  parameter int LOCKOUT_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] lockout,
  output logic [CHANNELS-1:0] conflict
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES + 1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sr_latch_chan #(
      .BOTH_MODE      (BOTH_MODE),
      .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s        (s[i]),
      .r        (r[i]),
      .q        (q[i]),
      .lockout  (lockout[i]),
      .conflict (conflict[i])
    );
  end

endmodule

// File: tb/tb_sr_latch_bank.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_bank
// Drives four copies of the bank (BOTH_MODE 0..3) with identical stimulus and
// compares every output each cycle against a behavioural model that tracks
// "is on" and "lockout cycles remaining" per channel.
// ---------------------------------------------------------------------------
module tb_sr_latch_bank;

  localparam int CH = 4;
  localparam int LC = 3;
  localparam int NM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] s, r;
  logic [CH-1:0] q_w  [NM];
  logic [CH-1:0] lo_w [NM];
  logic [CH-1:0] cf_w [NM];

  int tests = 0;
  int fails = 0;

  // Reference state: on/off, remaining lockout cycles, conflict flag
  bit m_on   [NM][CH];
  int m_left [NM][CH];
  bit m_cf   [NM][CH];

  for (genvar gm = 0; gm < NM; gm++) begin : g_dut
    sr_latch_bank #(
      .CHANNELS       (CH),
      .BOTH_MODE      (gm),
      .LOCKOUT_CYCLES (LC)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .s        (s),
      .r        (r),
      .q        (q_w[gm]),
      .lockout  (lo_w[gm]),
      .conflict (cf_w[gm])
    );
  end

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge
  task automatic modelStep(input bit rst_v, input logic [CH-1:0] sv,
                           input logic [CH-1:0] rv);
    for (int m = 0; m < NM; m++) begin
      for (int c = 0; c < CH; c++) begin
        bit both, want_on, want_off, tog;
        both     = sv[c] && rv[c];
        want_on  = (sv[c] && !rv[c]) || (both && m == 1);
        want_off = (rv[c] && !sv[c]) || (both && m == 0);
        tog      = both && m == 3;
        if (rst_v) begin
          m_on[m][c]   = 0;
          m_left[m][c] = 0;
          m_cf[m][c]   = 0;
        end else begin
          if (m_left[m][c] > 0) begin
            if (want_off) m_left[m][c] = LC;
            else          m_left[m][c] = m_left[m][c] - 1;
          end else if (m_on[m][c]) begin
            if (want_off || tog) begin
              m_on[m][c]   = 0;
              m_left[m][c] = LC;
            end
          end else if (want_on || tog) begin
            m_on[m][c] = 1;
          end
`ifdef SR_LATCH_BANK_STICKY_CONFLICT_EN
          m_cf[m][c] = m_cf[m][c] || both;
`else
          m_cf[m][c] = both;
`endif
        end
      end
    end
  endtask

  task automatic compareAll();
    for (int m = 0; m < NM; m++) begin
      logic [CH-1:0] eq, el, ec;
      for (int c = 0; c < CH; c++) begin
        eq[c] = m_on[m][c];
        el[c] = (m_left[m][c] > 0);
        ec[c] = m_cf[m][c];
      end
      checkOutput($sformatf("q mode%0d", m), 32'(q_w[m]), 32'(eq));
      checkOutput($sformatf("lockout mode%0d", m), 32'(lo_w[m]), 32'(el));
      checkOutput($sformatf("conflict mode%0d", m), 32'(cf_w[m]), 32'(ec));
    end
  endtask

  task automatic applyStimulus(input bit rst_v, input logic [CH-1:0] sv,
                               input logic [CH-1:0] rv);
    @(negedge clk);
    rst = rst_v;
    s   = sv;
    r   = rv;
    @(posedge clk);
    modelStep(rst_v, sv, rv);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0);
  endtask

  initial begin
    rst = 1'b1;
    s   = '0;
    r   = '0;

    // Reset with s all high, then release with s on channel 0
    applyStimulus(1'b1, 4'hF, 4'h0);
    applyStimulus(1'b1, 4'hF, 4'h0);
    applyStimulus(1'b0, 4'h1, 4'h0);

    // Channel 0: reset from ON, then hold s through the lockout
    applyStimulus(1'b0, 4'h0, 4'h1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h1, 4'h0);

    // Channel 1: r at count=1 extends lockout; s pulses inside are dropped
    applyStimulus(1'b0, 4'h2, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h2);
    applyStimulus(1'b0, 4'h2, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h2);
    applyStimulus(1'b0, 4'h2, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h2, 4'h0);
    idle(3);

    // Channel 2: simultaneous s/r from OFF and from ON
    applyStimulus(1'b0, 4'h4, 4'h4);
    idle(5);
    applyStimulus(1'b0, 4'h4, 4'h0);
    applyStimulus(1'b0, 4'h4, 4'h4);
    idle(5);

    // Channel 0: rst mid-lockout, then s accepted straight away
    applyStimulus(1'b0, 4'h1, 4'h0);
    applyStimulus(1'b0, 4'h0, 4'h1);
    applyStimulus(1'b1, 4'h0, 4'h0);
    applyStimulus(1'b0, 4'h1, 4'h0);
    idle(2);

    // Channel 3: single conflict cycle, watched for 20 cycles, then rst
    applyStimulus(1'b0, 4'h8, 4'h8);
    idle(20);
    applyStimulus(1'b1, 4'h0, 4'h0);

    // Random traffic with sparse requests and occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [CH-1:0] sv, rv;
      sv = CH'($urandom) & CH'($urandom);
      rv = CH'($urandom) & CH'($urandom) & CH'($urandom);
      applyStimulus($urandom_range(0, 39) == 0, sv, rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
